// File: rtl/seg_scroll_pkg.sv
// Shared glyph codes, active-low {g..a} segment patterns and the glyph decoder
// used by the scrolling banner and its per-digit decoders.
package seg_scroll_pkg;

  localparam int GLYPH_W = 5;

  localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 5'd16;
  localparam logic [GLYPH_W-1:0] GLYPH_H     = 5'd17;
  localparam logic [GLYPH_W-1:0] GLYPH_E     = 5'd18;
  localparam logic [GLYPH_W-1:0] GLYPH_L     = 5'd19;
  localparam logic [GLYPH_W-1:0] GLYPH_O     = 5'd20;
  localparam logic [GLYPH_W-1:0] GLYPH_C     = 5'd21;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {LED_UP, LED_DOWN} led_state_e;

  function automatic logic [6:0] glyph_to_seg(input logic [GLYPH_W-1:0] g);
    logic [6:0] s;
    s = SEG_BLANK;
    case (g)
      5'd0:    s = SEG_0;
      5'd1:    s = SEG_1;
      5'd2:    s = SEG_2;
      5'd3:    s = SEG_3;
      5'd4:    s = SEG_4;
      5'd5:    s = SEG_5;
      5'd6:    s = SEG_6;
      5'd7:    s = SEG_7;
      5'd8:    s = SEG_8;
      5'd9:    s = SEG_9;
      5'd10:   s = SEG_A;
      5'd11:   s = SEG_B;
      5'd12:   s = SEG_C;
      5'd13:   s = SEG_D;
      5'd14:   s = SEG_E;
      5'd15:   s = SEG_F;
      GLYPH_H: s = SEG_H;
      GLYPH_E: s = SEG_E;
      GLYPH_L: s = SEG_L;
      GLYPH_O: s = SEG_0;
      GLYPH_C: s = SEG_C;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scroll_ctrl_seg7_decode.sv
// Combinational glyph-to-segment decoder for one digit; zero latency, no flow control.
module seg7_decode
  import seg_scroll_pkg::*;
(
  input  logic [4:0] glyph,
  output logic [6:0] seg
);

  assign seg = glyph_to_seg(glyph);

endmodule

// File: rtl/seg_scroll_ctrl.sv
// Scrolling message banner plus bouncing LED bar; hex/ledr registered one cycle
// after the state they show, step/wrap are single-cycle pulses, no backpressure.
module seg_scroll_ctrl
  import seg_scroll_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 16,
  parameter int TICK_DIV   = 24000000,
  parameter int LED_COUNT  = 10,
  parameter int LED_DIV    = 1335000,
  localparam int LW = $clog2(MSG_LEN + 1),
  localparam int AW = $clog2(MSG_LEN)
)
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    pause,
  input  logic                    dir,
  input  logic [LW-1:0]           msg_len,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [4:0]              wr_data,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic [LED_COUNT-1:0]    ledr,
  output logic                    step,
  output logic                    wrap
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LDW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam int PW  = $clog2(MSG_LEN + NUM_DIGITS + 1);
  localparam int LPW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;

  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [PW-1:0]  p_q, p_d;
  logic           step_q, step_d, wrap_q, wrap_d;
  logic [LDW-1:0] led_cnt_q, led_cnt_d;
  logic [LPW-1:0] led_pos_q, led_pos_d;
  led_state_e     led_st_q, led_st_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [LED_COUNT-1:0]    ledr_q, ledr_d;
  logic [4:0]     msg_q [MSG_LEN];
  logic [4:0]     msg_d [MSG_LEN];

  logic [LW-1:0]  len_eff;
  logic [PW-1:0]  p_max;
  logic [4:0]     glyph [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] seg_all;
  int             idx;

  assign len_eff = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;
  assign p_max   = PW'(len_eff) + PW'(NUM_DIGITS);

  always_comb begin
    msg_d = msg_q;
    if (wr_en && (int'(wr_addr) < MSG_LEN)) msg_d[wr_addr] = wr_data;
  end

  // Digit d shows stream index p+N-1-d; the stream is N blanks, the message, N blanks.
  always_comb begin
    idx = 0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      idx      = int'(p_q) + NUM_DIGITS - 1 - d;
      glyph[d] = GLYPH_BLANK;
      if (idx >= NUM_DIGITS && idx < NUM_DIGITS + int'(len_eff))
        glyph[d] = msg_q[AW'(idx - NUM_DIGITS)];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .glyph (glyph[g]),
      .seg   (seg_all[7*g +: 7])
    );
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    p_d        = p_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    if (!enable) begin
      tick_cnt_d = '0;
      p_d        = '0;
    end else if (!pause) begin
      if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
        tick_cnt_d = '0;
        step_d     = 1'b1;
        // A shrunk message can leave p beyond the new end; restart from 0.
        if (p_q > p_max) begin
          p_d    = '0;
          wrap_d = 1'b1;
        end else if (!dir) begin
          if (p_q == p_max) begin
            p_d    = '0;
            wrap_d = 1'b1;
          end else begin
            p_d = p_q + PW'(1);
          end
        end else begin
          if (p_q == '0) begin
            p_d    = p_max;
            wrap_d = 1'b1;
          end else begin
            p_d = p_q - PW'(1);
          end
        end
      end else begin
        tick_cnt_d = tick_cnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    led_cnt_d = led_cnt_q;
    led_pos_d = led_pos_q;
    led_st_d  = led_st_q;
    if (!enable) begin
      led_cnt_d = '0;
      led_pos_d = '0;
      led_st_d  = LED_UP;
    end else if (!pause) begin
      if (led_cnt_q == LDW'(LED_DIV - 1)) begin
        led_cnt_d = '0;
        case (led_st_q)
          LED_UP: begin
            led_pos_d = led_pos_q + LPW'(1);
            if (led_pos_d == LPW'(LED_COUNT - 1)) led_st_d = LED_DOWN;
          end
          default: begin
            led_pos_d = led_pos_q - LPW'(1);
            if (led_pos_d == '0) led_st_d = LED_UP;
          end
        endcase
      end else begin
        led_cnt_d = led_cnt_q + LDW'(1);
      end
    end
  end

  always_comb begin
    hex_d  = enable ? seg_all : '1;
    ledr_d = enable ? (LED_COUNT'(1) << led_pos_q) : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      p_q        <= '0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      led_cnt_q  <= '0;
      led_pos_q  <= '0;
      led_st_q   <= LED_UP;
      hex_q      <= '1;
      ledr_q     <= '0;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= GLYPH_BLANK;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      p_q        <= p_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      led_cnt_q  <= led_cnt_d;
      led_pos_q  <= led_pos_d;
      led_st_q   <= led_st_d;
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      msg_q      <= msg_d;
    end
  end

  assign hex  = hex_q;
  assign ledr = ledr_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Scoreboard bench: a stream-level model predicts hex/ledr every cycle and wrap per step.
module tb_seg_scroll_ctrl;

  localparam int N  = 4;
  localparam int ML = 16;
  localparam int TD = 4;
  localparam int LC = 10;
  localparam int LD = 2;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] SH = 7'b0001001;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SL = 7'b1000111;

  logic        clock, reset, enable, pause, dir, wr_en;
  logic [4:0]  msg_len;
  logic [3:0]  wr_addr;
  logic [4:0]  wr_data;
  logic [27:0] hex;
  logic [9:0]  ledr;
  logic        step, wrap;

  seg_scroll_ctrl #(
    .NUM_DIGITS (N),
    .MSG_LEN    (ML),
    .TICK_DIV   (TD),
    .LED_COUNT  (LC),
    .LED_DIV    (LD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .pause   (pause),
    .dir     (dir),
    .msg_len (msg_len),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .hex     (hex),
    .ledr    (ledr),
    .step    (step),
    .wrap    (wrap)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [4:0] g);
    case (g)
      5'd0:  return 7'b1000000;  5'd1:  return 7'b1111001;
      5'd2:  return 7'b0100100;  5'd3:  return 7'b0110000;
      5'd4:  return 7'b0011001;  5'd5:  return 7'b0010010;
      5'd6:  return 7'b0000010;  5'd7:  return 7'b1111000;
      5'd8:  return 7'b0000000;  5'd9:  return 7'b0010000;
      5'd10: return 7'b0001000;  5'd11: return 7'b0000011;
      5'd12: return 7'b1000110;  5'd13: return 7'b0100001;
      5'd14: return 7'b0000110;  5'd15: return 7'b0001110;
      5'd17: return SH;          5'd18: return SE;
      5'd19: return SL;          5'd20: return 7'b1000000;
      5'd21: return 7'b1000110;
      default: return BL;
    endcase
  endfunction

  // Reference model state
  logic [4:0] m_msg [ML];
  int m_p, m_tick, m_led_ct, m_led_steps;
  int mlen, mpmax, np;
  bit w;

  typedef struct packed {
    logic [27:0] hex;
    logic [9:0]  ledr;
  } out_t;

  out_t q_out[$];
  bit   q_step[$];
  out_t e_out;

  function automatic logic [27:0] render(input int p, input int len);
    logic [4:0]  s[$];
    logic [27:0] h;
    int          i;
    for (int k = 0; k < N; k++) s.push_back(5'd16);
    for (int k = 0; k < len; k++) s.push_back(m_msg[k]);
    for (int k = 0; k < N; k++) s.push_back(5'd16);
    h = '1;
    for (int d = 0; d < N; d++) begin
      i = p + N - 1 - d;
      h[7*d +: 7] = (i < s.size()) ? seg_of(s[i]) : BL;
    end
    return h;
  endfunction

  function automatic int led_idx(input int k);
    int per, r;
    per = 2 * (LC - 1);
    r   = k % per;
    return (r < LC) ? r : per - r;
  endfunction

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        for (int i = 0; i < ML; i++) m_msg[i] = 5'd16;
        m_p = 0; m_tick = 0; m_led_ct = 0; m_led_steps = 0;
        q_out.delete();
        q_step.delete();
      end else begin
        mlen  = (int'(msg_len) > ML) ? ML : int'(msg_len);
        mpmax = mlen + N;
        e_out.hex  = enable ? render(m_p, mlen) : 28'hFFFFFFF;
        e_out.ledr = enable ? 10'(1 << led_idx(m_led_steps)) : 10'd0;
        q_out.push_back(e_out);
        if (wr_en && int'(wr_addr) < ML) m_msg[wr_addr] = wr_data;
        if (!enable) begin
          m_p = 0; m_tick = 0; m_led_ct = 0; m_led_steps = 0;
        end else if (!pause) begin
          m_tick++;
          if (m_tick == TD) begin
            m_tick = 0;
            if (m_p > mpmax) begin
              np = 0; w = 1'b1;
            end else if (!dir) begin
              np = (m_p + 1) % (mpmax + 1); w = (np == 0);
            end else begin
              np = (m_p + mpmax) % (mpmax + 1); w = (np == mpmax);
            end
            m_p = np;
            q_step.push_back(w);
          end
          m_led_ct++;
          if (m_led_ct == LD) begin
            m_led_ct = 0;
            m_led_steps++;
          end
        end
      end
    end
  end

  out_t eo;
  bit   exp_step, exp_wrap;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (q_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_queue empty at %0t", $time);
        end else begin
          eo = q_out.pop_front();
          chk("hex", 64'(hex), 64'(eo.hex));
          chk("ledr", 64'(ledr), 64'(eo.ledr));
        end
        exp_step = (q_step.size() > 0);
        exp_wrap = exp_step ? q_step.pop_front() : 1'b0;
        chk("step", 64'(step), 64'(exp_step));
        chk("wrap", 64'(wrap), 64'(exp_wrap));
      end
    end
  end

  task automatic wait_step(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!step && n < 100);
    if (!step) begin
      checks++; errors++;
      $display("FAIL %s step timeout actual=none required=step", name);
    end
  endtask

  task automatic cycles_to_step(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!step && n < 50);
  endtask

  logic [4:0] hello [5];
  int n_cyc;

  initial begin
    hello = '{5'd17, 5'd18, 5'd19, 5'd19, 5'd20};
    reset = 1'b1; enable = 1'b0; pause = 1'b0; dir = 1'b0;
    msg_len = 5'd0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 5'd0;
    repeat (3) @(negedge clock);
    chk("rst_hex", 64'(hex), 64'(28'hFFFFFFF));
    chk("rst_ledr", 64'(ledr), 64'(0));
    chk("rst_step", 64'(step), 64'(0));
    chk("rst_wrap", 64'(wrap), 64'(0));
    #2 reset = 1'b0;

    // HELLO loaded while disabled, then forward scroll
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = hello[i];
    end
    @(negedge clock);
    wr_en = 1'b0; msg_len = 5'd5; dir = 1'b0; enable = 1'b1;
    wait_step("s1");
    @(negedge clock);
    chk("hello_s1", 64'(hex), 64'({BL, BL, BL, SH}));
    repeat (3) wait_step("s2_4");
    @(negedge clock);
    chk("hello_s4", 64'(hex), 64'({SH, SE, SL, SL}));
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 5'd0;
    @(negedge clock);
    wr_en = 1'b0;
    @(negedge clock);
    chk("live_digit2", 64'(hex[20:14]), 64'(7'b1000000));
    repeat (5) wait_step("s5_9");
    @(negedge clock);
    chk("hello_s9", 64'(hex), 64'(28'hFFFFFFF));
    wait_step("s10");
    chk("wrap_s10", 64'(wrap), 64'(1));

    // Reverse from p=0, then shrink at p=8
    dir = 1'b1;
    wait_step("rev1");
    chk("wrap_rev", 64'(wrap), 64'(1));
    wait_step("rev2");
    chk("nowrap_rev2", 64'(wrap), 64'(0));
    msg_len = 5'd2;
    wait_step("shrink");
    chk("wrap_shrink", 64'(wrap), 64'(1));

    // Pause two cycles after a step
    dir = 1'b0; msg_len = 5'd5;
    wait_step("pre_pause");
    @(negedge clock);
    @(negedge clock);
    pause = 1'b1;
    repeat (50) @(negedge clock);
    pause = 1'b0;
    cycles_to_step(n_cyc);
    chk("pause_resume", 64'(n_cyc), 64'(2));

    // Asynchronous reset mid-run
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_hex", 64'(hex), 64'(28'hFFFFFFF));
    chk("arst_ledr", 64'(ledr), 64'(0));
    chk("arst_step", 64'(step), 64'(0));
    @(negedge clock);
    #2 reset = 1'b0;
    cycles_to_step(n_cyc);
    chk("first_step_after_reset", 64'(n_cyc), 64'(4));

    // Let the LED bounce a full period, then disable
    repeat (40) @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    chk("ledr_en_low", 64'(ledr), 64'(0));
    chk("hex_en_low", 64'(hex), 64'(28'hFFFFFFF));

    // Randomised traffic
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      wr_en   = ($urandom_range(0, 99) < 30);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) < 3) msg_len = 5'($urandom_range(0, 20));
      if ($urandom_range(0, 99) < 2) dir = ~dir;
      if ($urandom_range(0, 99) < 4) pause = ~pause;
      enable = ($urandom_range(0, 199) != 0);
    end
    wr_en = 1'b0; pause = 1'b0; enable = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scroll_ctrl.md
# seg_scroll_ctrl

Parametrised scrolling-message and LED-bar engine for the board's seven-segment displays and red LED row. It generalises the fixed four-digit banner and fixed ten-LED bouncer into one block with these properties:
- Runtime-loadable message of up to MSG_LEN glyphs.
- Any digit count.
- Independent scroll and LED-step rates.
- Pause and reverse-direction modes.

It sits between the switch/key decode logic and the hex/ledr output pins.

## Interface
- NUM_DIGITS, 4: seven-segment digits driven; digit NUM_DIGITS-1 is leftmost.
- MSG_LEN, 16: message buffer depth, in glyphs.
- TICK_DIV, 24000000: clock cycles per scroll step.
- LED_COUNT, 10: LED bar width.
- LED_DIV, 1335000: clock cycles per LED step.
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run; when low, both engines are held at position 0 with outputs blank/off.
- pause  in  1  freezes prescalers and positions; outputs hold.
- dir  in  1  0 = scroll left (text enters from the right), 1 = reverse.
- msg_len  in  clog2(MSG_LEN+1)  active message length; values above MSG_LEN clamp to MSG_LEN.
- wr_en  in  1  message write strobe.
- wr_addr  in  clog2(MSG_LEN)  glyph index; out-of-range writes are ignored.
- wr_data  in  5  glyph code.
- hex  out  7*NUM_DIGITS  active-low segments {g..a} per digit; digit d occupies [7d+6:7d].
- ledr  out  LED_COUNT  one-hot bouncing LED.
- step  out  1  one-cycle pulse on each scroll advance.
- wrap  out  1  one-cycle pulse, coincident with step, when the position wraps.

## Operation
- Glyph codes: 0–15 are hex digits, 16 blank, 17 H, 18 E, 19 L, 20 O, 21 C.
  - Segment patterns follow the board's existing decode; for example, 0 = 7'b1000000, H = 7'b0001001, blank = 7'b1111111.
  - Codes 22–31 decode to blank.
- Virtual stream S of length msg_len + 2·NUM_DIGITS:
  - S[i] = blank for i < NUM_DIGITS or i ≥ NUM_DIGITS + msg_len.
  - Otherwise S[i] = msg[i−NUM_DIGITS].
- Scroll position p ranges over 0..P_MAX, where P_MAX = msg_len + NUM_DIGITS. Digit d shows S[p + NUM_DIGITS−1−d]. At p = 0 and at p = P_MAX the display is all blank.
- Scroll prescaler counts 0..TICK_DIV−1. At terminal count it raises step and advances p:
  - dir = 0: p+1, wrapping P_MAX → 0.
  - dir = 1: p−1, wrapping 0 → P_MAX.
  - wrap is asserted on those wrapping transitions.
- If msg_len shrinks so that p > P_MAX, the next step loads p = 0 in either direction, with wrap asserted.
- LED engine runs its own prescaler (0..LED_DIV−1) over a 2-state FSM:
  - UP: led_pos+1, moving to DOWN when led_pos reaches LED_COUNT−1.
  - DOWN: led_pos−1, moving to UP when led_pos reaches 0.
  - The sequence is 0,1,…,LED_COUNT−1,…,1,0 with period 2·(LED_COUNT−1) steps.
  - ledr = 1 << led_pos while enable is high; otherwise 0.
- Writes to the message buffer are accepted in every mode, including pause and enable low.
- Priority, highest first: reset > enable low > pause > step.
  - enable low clears both prescalers, p, led_pos and the FSM (to UP).

## Timing
- Reset values:
  - hex all ones (blank), ledr 0, step 0, wrap 0.
  - p = 0, led_pos = 0, FSM = UP, prescalers 0.
  - Message buffer is filled with blank (16).
- hex and ledr are registered, one cycle after the state they reflect.
  - A write at edge k is visible on hex at edge k+1 if the glyph is in the window.
- step and wrap are registered pulses, high in the cycle after the terminal count, in the same cycle as the new p.
- Pause asserted at cycle k: prescaler values at k are held exactly, and counting resumes from them on release; no step is lost or duplicated.
- Reset assertion mid-scroll immediately blanks hex, clears ledr, and returns all state to reset values.

## Structure
- Package seg_scroll_pkg holds:
  - the glyph code constants (GLYPH_BLANK, GLYPH_H, …);
  - the 7-bit active-low segment constants;
  - function glyph_to_seg.
- Sub-module seg7_decode is one combinational glyph→segment instance per digit, generated NUM_DIGITS times.
- Message buffer is a register array with combinational read; no RAM macro.

## Test plan
All scenarios use NUM_DIGITS=4, MSG_LEN=16, TICK_DIV=4, LED_COUNT=10, LED_DIV=2.
- Reset: assert reset mid-run → hex = 28'hFFFFFFF, ledr = 0, step = 0 asynchronously; after release with enable=1, first step occurs after 4 cycles.
- Forward scroll: load HELLO = 17,18,19,19,20 at addresses 0–4, msg_len=5, dir=0:
  - step 1 → digits 3..0 = blank,blank,blank,H;
  - step 4 → H,E,L,L;
  - step 9 → all blank;
  - step 10 → p=0 with wrap=1.
- Reverse and shrink:
  - dir=1 from p=0 → next step gives p=9 with wrap=1.
  - Separately, at p=8 set msg_len=2 → next step gives p=0 with wrap=1.
- Pause: assert pause 2 cycles after a step and hold 50 cycles → hex, ledr and the prescalers are frozen; after release, the next step occurs exactly 2 cycles later.
- LED bounce: from enable, ledr one-hot index follows 0..9,8..1,0 at 2-cycle spacing; enable low → ledr=0 the next cycle.
- Live write: while displaying H,E,L,L, write glyph 0 to address 1 → the second digit shows 7'b1000000 one cycle later, and step timing is unaffected.
